// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: MEM stage vs debug/loader, with a bounded-starvation streak counter.
// Latency: zero-cycle combinational grant and memory path; debug read data registered one cycle later; backpressure by pipe_stall / held dbg_req.
module dmem_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_req,
  input  logic        pipe_we,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        pipe_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_valid,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_DBG  = 2'd2
  } gnt_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

  gnt_e        gnt;
  mem_cmd_t    cmd;
  logic [3:0]  streak;
  logic [3:0]  streak_nxt;
  logic        streak_full;
  logic        rd_pend;
  logic [31:0] rdata_q;
  logic        dbg_rd_gnt;

  assign streak_full = (streak == STREAK_LIM);

  // Reset blocks every grant so no memory access escapes while rst is low.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      gnt = GNT_NONE;
    end else if (pipe_req && !(dbg_req && streak_full)) begin
      gnt = GNT_PIPE;
    end else if (dbg_req) begin
      gnt = GNT_DBG;
    end
  end

  always_comb begin
    cmd = '0;
    case (gnt)
      GNT_PIPE: begin
        cmd.rd    = ~pipe_we;
        cmd.wr    = pipe_we;
        cmd.addr  = pipe_addr;
        cmd.wdata = pipe_wdata;
      end
      GNT_DBG: begin
        cmd.rd    = ~dbg_we;
        cmd.wr    = dbg_we;
        cmd.addr  = dbg_addr;
        cmd.wdata = dbg_wdata;
      end
      default: cmd = '0;
    endcase
  end

  assign mem_rd     = cmd.rd;
  assign mem_wr     = cmd.wr;
  assign mem_addr   = cmd.addr;
  assign mem_wdata  = cmd.wdata;
  assign pipe_rdata = (gnt == GNT_PIPE) ? mem_rdata : 32'd0;
  assign pipe_stall = (gnt == GNT_DBG) && pipe_req;
  assign dbg_gnt    = (gnt == GNT_DBG);
  assign dbg_rd_gnt = dbg_gnt && !dbg_we;

  // Streak only counts pipeline wins while debug is actually waiting.
  always_comb begin
    streak_nxt = streak;
    if (!dbg_req || dbg_gnt) begin
      streak_nxt = 4'd0;
    end else if ((gnt == GNT_PIPE) && !streak_full) begin
      streak_nxt = streak + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak  <= 4'd0;
      rd_pend <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      streak  <= streak_nxt;
      rd_pend <= dbg_rd_gnt;
      if (dbg_rd_gnt) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Gating with rst drops a read whose strobe would land in the first reset cycle.
  assign dbg_valid = rd_pend && rst;
  assign dbg_rdata = rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STREAK_MAX, default 4: consecutive pipeline grants with a debug request pending before debug is forced a slot; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port pipe_req, input, 1: MEM-stage access request (EX_M_MR | EX_M_MW).
REQ-005 SHALL have port pipe_we, input, 1: 1 = MEM-stage write, 0 = read.
REQ-006 SHALL have port pipe_addr, input, 32: MEM-stage address (ALU_Result_1).
REQ-007 SHALL have port pipe_wdata, input, 32: MEM-stage store data (Write_Data).
REQ-008 SHALL have port pipe_rdata, output, 32: read data returned to the M_WB stage.
REQ-009 SHALL have port pipe_stall, output, 1: freezes PC, IF_ID, ID_EX and EX_M for the current cycle.
REQ-010 SHALL have port dbg_req, input, 1: debug/loader request, held until granted.
REQ-011 SHALL have ports dbg_we (1), dbg_addr (32) and dbg_wdata (32), all inputs: debug write flag, address and write data.
REQ-012 SHALL have port dbg_gnt, output, 1: debug request accepted this cycle.
REQ-013 SHALL have ports dbg_rdata, output, 32, and dbg_valid, output, 1: registered debug read data and its one-cycle valid strobe.
REQ-014 SHALL have ports mem_rd, output, 1; mem_wr, output, 1; mem_addr, output, 32; mem_wdata, output, 32: data-memory command signals.
REQ-015 SHALL have port mem_rdata, input, 32: data-memory read data, combinational from mem_addr within the same cycle.

Function
REQ-016 SHALL grant at most one requester per cycle; the grant decision is combinational from the current requests and the registered streak counter.
REQ-017 SHALL grant the pipeline when pipe_req=1 and NOT (dbg_req=1 and streak==STREAK_MAX).
REQ-018 SHALL grant debug when dbg_req=1 and (pipe_req=0 or streak==STREAK_MAX).
REQ-019 SHALL, on a pipeline grant, drive mem_addr=pipe_addr, mem_wdata=pipe_wdata, mem_wr=pipe_we, mem_rd=~pipe_we, pipe_rdata=mem_rdata and pipe_stall=0, giving zero added latency.
REQ-020 SHALL, on a debug grant, drive the mem_* signals from the dbg_* inputs and assert dbg_gnt=1.
REQ-021 SHALL, on a debug grant while pipe_req=1, assert pipe_stall=1; the pipeline holds its request and is retried the next cycle.
REQ-022 SHALL, on a granted debug read, register mem_rdata into dbg_rdata and pulse dbg_valid=1 for exactly one cycle in the following cycle; a debug write SHALL NOT pulse dbg_valid.
REQ-023 SHALL hold dbg_rdata between reads.
REQ-024 SHALL update the streak counter (4 bits) each cycle:
- increment by 1 on a pipeline grant while dbg_req=1, saturating at STREAK_MAX;
- clear to 0 on any debug grant;
- clear to 0 on any cycle with dbg_req=0.
REQ-025 SHALL drive mem_rd=mem_wr=0, pipe_stall=0 and dbg_gnt=0 when neither requester is granted; mem_addr and mem_wdata hold 0 in that case.
REQ-026 SHALL, with pipe_req=0, grant back-to-back debug accesses every cycle while dbg_req=1.
REQ-027 SHALL never assert mem_rd and mem_wr together.
REQ-028 SHALL never assert pipe_stall when pipe_req=0.

Reset
REQ-029 SHALL, while rst=0 at a clock edge, clear the streak counter and dbg_rdata to 0 and dbg_valid to 0.
REQ-030 SHALL, while rst=0, force dbg_gnt=0, pipe_stall=0, mem_rd=0 and mem_wr=0 combinationally; no access is issued during reset.
REQ-031 SHALL discard a debug read granted in the cycle before reset asserts: no dbg_valid pulse after reset.

Verification
REQ-032 Pipeline only: pipe_req=1, pipe_we=0, addr=0x10, mem_rdata=0xCAFE0001 -> pipe_rdata=0xCAFE0001 in the same cycle, pipe_stall=0, mem_rd=1.
REQ-033 Debug only: dbg_req=1, dbg_we=0, addr=0x20, mem_rdata=0x12345678 -> dbg_gnt=1 in cycle N; dbg_valid=1 with dbg_rdata=0x12345678 in cycle N+1 only.
REQ-034 Contention, STREAK_MAX=4: pipe_req and dbg_req held at 1 -> pipeline granted in cycles 0-3; debug granted with pipe_stall=1 in cycle 4; pipeline granted in cycles 5-8.
REQ-035 Debug write 0xDEADBEEF to 0x8 with pipe_req=0 -> mem_wr=1, mem_wdata=0xDEADBEEF, dbg_gnt=1, and dbg_valid stays 0 throughout.
REQ-036 Reset mid-operation: debug read granted in cycle N, rst=0 in cycle N+1 -> dbg_valid=0 and streak=0; after rst=1, a pipeline request is granted immediately.
REQ-037 Idle: both requests 0 for 10 cycles -> mem_rd=mem_wr=0, pipe_stall=0, streak=0 throughout.
